// File: rtl/bus_ctrl_pkg.sv
// Shared types and default memory map for the CPU bus controller.
package bus_ctrl_pkg;

    localparam int unsigned WAIT_W     = 4;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_N_REG  = 4;
    localparam int unsigned DEF_N_IRQ  = 2;

    // Region 0 in the LSBs: RAM 0000-3FFF, 5000-500F (1 wait), 6000-600F (2 waits), 8000-FFFF.
    localparam logic [DEF_N_REG*DEF_ADDR_W-1:0] DEF_REG_BASE =
        {16'h8000, 16'h6000, 16'h5000, 16'h0000};
    localparam logic [DEF_N_REG*DEF_ADDR_W-1:0] DEF_REG_MASK =
        {16'h8000, 16'hFFF0, 16'hFFF0, 16'hC000};
    localparam logic [DEF_N_REG*WAIT_W-1:0]     DEF_REG_WAIT =
        {4'd0, 4'd2, 4'd1, 4'd0};
    localparam logic [DEF_DATA_W-1:0]           DEF_OPEN_BUS = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/bus_region_decode.sv
// Combinational address decoder: one-hot region select and its wait-state count.
module bus_region_decode
    import bus_ctrl_pkg::*;
#(
    parameter int unsigned                    ADDR_W   = DEF_ADDR_W,
    parameter int unsigned                    N_REG    = DEF_N_REG,
    parameter logic [N_REG*ADDR_W-1:0]        REG_BASE = DEF_REG_BASE,
    parameter logic [N_REG*ADDR_W-1:0]        REG_MASK = DEF_REG_MASK,
    parameter logic [N_REG*WAIT_W-1:0]        REG_WAIT = DEF_REG_WAIT
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [N_REG-1:0]  o_cs,
    output logic [WAIT_W-1:0] o_wait
);

    // Scan from the highest region down so the lowest-index hit overrides.
    always_comb begin
        o_cs   = '0;
        o_wait = '0;
        for (int r = N_REG - 1; r >= 0; r--) begin
            if ((i_addr & REG_MASK[r*ADDR_W +: ADDR_W]) ==
                (REG_BASE[r*ADDR_W +: ADDR_W] & REG_MASK[r*ADDR_W +: ADDR_W])) begin
                o_cs    = '0;
                o_cs[r] = 1'b1;
                o_wait  = REG_WAIT[r*WAIT_W +: WAIT_W];
            end
        end
    end

endmodule

// File: rtl/bus_ctrl.sv
// CPU bus controller: address/strobe register, region decode, wait-state FSM,
// read-data mux, unmapped-access pulse and interrupt combine.
module bus_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int unsigned                    ADDR_W   = DEF_ADDR_W,
    parameter int unsigned                    DATA_W   = DEF_DATA_W,
    parameter int unsigned                    N_REG    = DEF_N_REG,
    parameter logic [N_REG*ADDR_W-1:0]        REG_BASE = DEF_REG_BASE,
    parameter logic [N_REG*ADDR_W-1:0]        REG_MASK = DEF_REG_MASK,
    parameter logic [N_REG*WAIT_W-1:0]        REG_WAIT = DEF_REG_WAIT,
    parameter int unsigned                    N_IRQ    = DEF_N_IRQ,
    parameter logic [DATA_W-1:0]              OPEN_BUS = DEF_OPEN_BUS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       cpu_ad,
    input  logic                    cpu_we,
    output logic [DATA_W-1:0]       cpu_di,
    output logic                    cpu_rdy,
    output logic                    cpu_irq,
    output logic [ADDR_W-1:0]       addr,
    output logic                    we,
    output logic [N_REG-1:0]        cs,
    input  logic [N_REG*DATA_W-1:0] dev_do,
    input  logic [N_IRQ-1:0]        irq_n,
    output logic                    bus_err
);

    state_t              r_state;
    state_t              w_state_nx;
    logic [WAIT_W-1:0]   r_cnt;
    logic [WAIT_W-1:0]   w_cnt_nx;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic                r_irq;
    logic                r_err;
    logic                w_rdy;
    logic [N_REG-1:0]    w_cs;
    logic [WAIT_W-1:0]   w_wait;
    logic [DATA_W-1:0]   w_di;

    bus_region_decode #(
        .ADDR_W   (ADDR_W),
        .N_REG    (N_REG),
        .REG_BASE (REG_BASE),
        .REG_MASK (REG_MASK),
        .REG_WAIT (REG_WAIT)
    ) u_decode (
        .i_addr (r_addr),
        .o_cs   (w_cs),
        .o_wait (w_wait)
    );

    // FSM state and wait counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Next state and ready: IDLE spends the first wait cycle, WAIT counts the rest.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rdy      = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_wait != '0) begin
                    w_rdy      = 1'b0;
                    w_state_nx = WAIT;
                    w_cnt_nx   = w_wait - WAIT_W'(1);
                end
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_rdy    = 1'b0;
                    w_cnt_nx = r_cnt - WAIT_W'(1);
                end else begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Bus-side registers: address/strobe load on ready, error pulse, interrupt level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_we   <= 1'b0;
            r_err  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (w_rdy) begin
                r_addr <= cpu_ad;
                r_we   <= cpu_we;
            end
            r_err <= (r_state == IDLE) && (w_cs == '0);
            r_irq <= |(~irq_n);
        end
    end

    // Read-data mux from the selected device, open-bus value when nothing hits.
    always_comb begin
        w_di = OPEN_BUS;
        for (int r = 0; r < N_REG; r++) begin
            if (w_cs[r]) begin
                w_di = dev_do[r*DATA_W +: DATA_W];
            end
        end
    end

    assign addr    = r_addr;
    assign we      = r_we;
    assign cs      = w_cs;
    assign cpu_rdy = w_rdy;
    assign cpu_di  = w_di;
    assign bus_err = r_err;
    assign cpu_irq = r_irq;

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: directed vector table, transaction-level
// reference model under random stimulus, and a 15-wait-state instance.
module tb_bus_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_ad;
    logic        cpu_we;
    logic [31:0] dev_do;
    logic [1:0]  irq_n;

    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        cpu_irq;
    logic [15:0] addr;
    logic        we;
    logic [3:0]  cs;
    logic        bus_err;

    logic [7:0]  d15_di;
    logic        d15_rdy;
    logic        d15_irq;
    logic [15:0] d15_addr;
    logic        d15_we;
    logic [3:0]  d15_cs;
    logic        d15_err;

    int n_chk = 0;
    int n_err = 0;

    bus_ctrl u_dut (
        .clk     (clk),
        .reset   (reset),
        .cpu_ad  (cpu_ad),
        .cpu_we  (cpu_we),
        .cpu_di  (cpu_di),
        .cpu_rdy (cpu_rdy),
        .cpu_irq (cpu_irq),
        .addr    (addr),
        .we      (we),
        .cs      (cs),
        .dev_do  (dev_do),
        .irq_n   (irq_n),
        .bus_err (bus_err)
    );

    bus_ctrl #(
        .REG_WAIT ({4'd0, 4'd2, 4'd15, 4'd0})
    ) u_dut15 (
        .clk     (clk),
        .reset   (reset),
        .cpu_ad  (cpu_ad),
        .cpu_we  (cpu_we),
        .cpu_di  (d15_di),
        .cpu_rdy (d15_rdy),
        .cpu_irq (d15_irq),
        .addr    (d15_addr),
        .we      (d15_we),
        .cs      (d15_cs),
        .dev_do  (dev_do),
        .irq_n   (irq_n),
        .bus_err (d15_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Memory map as the CPU sees it.
    localparam logic [15:0] T_BASE [4] = '{16'h0000, 16'h5000, 16'h6000, 16'h8000};
    localparam logic [15:0] T_MASK [4] = '{16'hC000, 16'hFFF0, 16'hFFF0, 16'h8000};
    localparam int          T_WAIT [4] = '{0, 1, 2, 0};

    function automatic int region_of(input logic [15:0] a);
        for (int r = 0; r < 4; r++)
            if ((a & T_MASK[r]) == (T_BASE[r] & T_MASK[r])) return r;
        return -1;
    endfunction

    function automatic int wait_of(input logic [15:0] a);
        int r;
        r = region_of(a);
        return (r < 0) ? 0 : T_WAIT[r];
    endfunction

    // Transaction model: each access holds the bus for k low cycles then one ready cycle.
    logic [15:0] m_addr;
    logic        m_we;
    int          m_left;
    bit          m_first;
    bit          m_err;
    bit          m_irq;
    bit          m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int    r;
        logic [3:0] e_cs;
        logic [7:0] e_di;
        r = region_of(m_addr);
        e_cs = (r < 0) ? 4'b0000 : 4'(1 << r);
        e_di = (r < 0) ? 8'hFF : dev_do[r*8 +: 8];
        chk("m_addr",  32'(addr),    32'(m_addr));
        chk("m_we",    32'(we),      32'(m_we));
        chk("m_cs",    32'(cs),      32'(e_cs));
        chk("m_rdy",   32'(cpu_rdy), 32'(m_left == 0));
        chk("m_di",    32'(cpu_di),  32'(e_di));
        chk("m_err",   32'(bus_err), 32'(m_err));
        chk("m_irq",   32'(cpu_irq), 32'(m_irq));
    endtask

    task automatic model_update();
        if (reset) begin
            m_addr  = 16'h0000;
            m_we    = 1'b0;
            m_left  = wait_of(16'h0000);
            m_first = 1'b1;
            m_err   = 1'b0;
            m_irq   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_err = m_first && (region_of(m_addr) < 0);
            m_irq = (irq_n != 2'b11);
            if (m_left == 0) begin
                m_addr  = cpu_ad;
                m_we    = cpu_we;
                m_left  = wait_of(cpu_ad);
                m_first = 1'b1;
            end else begin
                m_left  = m_left - 1;
                m_first = 1'b0;
            end
        end
    endtask

    // One clock: check current outputs, drive inputs for the next edge, advance.
    task automatic step(input logic rst, input logic [15:0] ad, input logic w,
                        input logic [31:0] dd, input logic [1:0] irqn);
        if (m_valid) model_check();
        reset  = rst;
        cpu_ad = ad;
        cpu_we = w;
        dev_do = dd;
        irq_n  = irqn;
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [15:0] ad;
        logic        w;
        logic [1:0]  irqn;
        logic [15:0] e_addr;
        logic        e_we;
        logic [3:0]  e_cs;
        logic        e_rdy;
        logic [7:0]  e_di;
        logic        e_err;
        logic        e_irq;
    } vec_t;

    localparam int          NV = 18;
    localparam logic [31:0] DD = 32'h4433_22A5;

    vec_t        vt [NV];
    logic [15:0] rad;
    int          lows;
    bit          stable;

    initial begin
        reset  = 1'b1;
        cpu_ad = 16'h0000;
        cpu_we = 1'b0;
        dev_do = DD;
        irq_n  = 2'b11;

        //          rst   ad        w     irqn   addr      we    cs       rdy   di     err   irq
        vt[0]  = '{1'b1, 16'h1234, 1'b0, 2'b00, 16'h0000, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 16'h1234, 1'b0, 2'b11, 16'h1234, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 16'h6004, 1'b0, 2'b10, 16'h6004, 1'b0, 4'b0100, 1'b0, 8'h33, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 16'hABCD, 1'b1, 2'b11, 16'h6004, 1'b0, 4'b0100, 1'b0, 8'h33, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 16'hABCD, 1'b1, 2'b11, 16'h6004, 1'b0, 4'b0100, 1'b1, 8'h33, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 16'h5001, 1'b0, 2'b11, 16'h5001, 1'b0, 4'b0010, 1'b0, 8'h22, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 16'h6000, 1'b0, 2'b11, 16'h5001, 1'b0, 4'b0010, 1'b1, 8'h22, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 16'h6000, 1'b0, 2'b11, 16'h6000, 1'b0, 4'b0100, 1'b0, 8'h33, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 16'h6000, 1'b0, 2'b11, 16'h6000, 1'b0, 4'b0100, 1'b0, 8'h33, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 16'h4000, 1'b0, 2'b11, 16'h6000, 1'b0, 4'b0100, 1'b1, 8'h33, 1'b0, 1'b0};
        vt[10] = '{1'b0, 16'h4000, 1'b0, 2'b11, 16'h4000, 1'b0, 4'b0000, 1'b1, 8'hFF, 1'b0, 1'b0};
        vt[11] = '{1'b0, 16'h1234, 1'b0, 2'b11, 16'h1234, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 1'b0};
        vt[12] = '{1'b0, 16'h1234, 1'b0, 2'b11, 16'h1234, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[13] = '{1'b0, 16'h6000, 1'b0, 2'b11, 16'h6000, 1'b0, 4'b0100, 1'b0, 8'h33, 1'b0, 1'b0};
        vt[14] = '{1'b0, 16'h0000, 1'b0, 2'b11, 16'h6000, 1'b0, 4'b0100, 1'b0, 8'h33, 1'b0, 1'b0};
        vt[15] = '{1'b1, 16'h6004, 1'b0, 2'b11, 16'h0000, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[16] = '{1'b0, 16'h8000, 1'b1, 2'b11, 16'h8000, 1'b1, 4'b1000, 1'b1, 8'h44, 1'b0, 1'b0};
        vt[17] = '{1'b0, 16'h0000, 1'b0, 2'b11, 16'h0000, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b0, 1'b0};

        // Directed vectors: expected outputs just after each edge.
        for (int i = 0; i < NV; i++) begin
            step(vt[i].rst, vt[i].ad, vt[i].w, DD, vt[i].irqn);
            chk($sformatf("tv%0d_addr", i), 32'(addr),    32'(vt[i].e_addr));
            chk($sformatf("tv%0d_we",   i), 32'(we),      32'(vt[i].e_we));
            chk($sformatf("tv%0d_cs",   i), 32'(cs),      32'(vt[i].e_cs));
            chk($sformatf("tv%0d_rdy",  i), 32'(cpu_rdy), 32'(vt[i].e_rdy));
            chk($sformatf("tv%0d_di",   i), 32'(cpu_di),  32'(vt[i].e_di));
            chk($sformatf("tv%0d_err",  i), 32'(bus_err), 32'(vt[i].e_err));
            chk($sformatf("tv%0d_irq",  i), 32'(cpu_irq), 32'(vt[i].e_irq));
        end

        // Random traffic against the transaction model.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0:       rad = 16'($urandom_range(0, 16'h3FFF));
                1:       rad = 16'h5000 | 16'($urandom_range(0, 15));
                2:       rad = 16'h6000 | 16'($urandom_range(0, 15));
                3:       rad = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                4:       rad = 16'h4000 | 16'($urandom_range(0, 16'h0FFF));
                default: rad = 16'($urandom);
            endcase
            step(($urandom_range(0, 49) == 0), rad, 1'($urandom_range(0, 1)),
                 $urandom, 2'($urandom_range(0, 3)));
        end

        // 15 wait states on the second instance: 15 low cycles, address held, then reload.
        step(1'b1, 16'h0000, 1'b0, DD, 2'b11);
        step(1'b0, 16'h5001, 1'b0, DD, 2'b11);
        lows   = 0;
        stable = 1'b1;
        for (int i = 0; i < 40 && !d15_rdy; i++) begin
            lows++;
            if (d15_addr !== 16'h5001 || d15_cs !== 4'b0010) stable = 1'b0;
            step(1'b0, 16'h1234, 1'b0, DD, 2'b11);
        end
        chk("k15_low_cycles", 32'(lows), 32'd15);
        chk("k15_stable", 32'(stable), 32'd1);
        step(1'b0, 16'h1234, 1'b0, DD, 2'b11);
        chk("k15_reload_addr", 32'(d15_addr), 32'h1234);
        chk("k15_reload_rdy", 32'(d15_rdy), 32'd1);

        model_check();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
